// File: rtl/loop_over_all_nibbles_if.sv
// rtl/loop_over_all_nibbles_if.sv - control/operand/result bundle for the nibble-serial ALU
//
// master: the control FSM (drives request, opcode, operands, mode bits; reads result/busy)
// slave : the ALU (loop_over_all_nibbles)
interface loop_over_all_nibbles_if;
    logic        loop_perm_to_count;
    logic [4:0]  ctrl;
    logic [31:0] word1;
    logic [31:0] word2;
    logic [31:0] preinit_result;
    logic [2:0]  loop_nibbles_number;
    logic        word2_is_signed_and_negative;
    logic        check_if_result_0xF;
    logic        carry_in;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;

    modport master (
        output loop_perm_to_count, ctrl, word1, word2, preinit_result,
               loop_nibbles_number, word2_is_signed_and_negative,
               check_if_result_0xF, carry_in,
        input  result, carry_out, busy
    );

    modport slave (
        input  loop_perm_to_count, ctrl, word1, word2, preinit_result,
               loop_nibbles_number, word2_is_signed_and_negative,
               check_if_result_0xF, carry_in,
        output result, carry_out, busy
    );
endinterface

// File: rtl/loop_over_all_nibbles.sv
// rtl/loop_over_all_nibbles.sv - nibble-serial 32-bit ALU (one nibble per clock, LSB first)
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - loop_over_all_nibbles_if.slave: request/opcode/operands in, result/carry_out/busy out
// Parameter:
//   NIBBLES - nibbles per word (8); the nibble index is 3 bits wide
// Build option:
//   NIBBLE_ALU_SUB_EN - when defined, ctrl=5 performs SUB; otherwise ctrl=5 acts as ADD
module loop_over_all_nibbles #(
    parameter int NIBBLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    loop_over_all_nibbles_if.slave    bus
);

    localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);

    typedef enum logic {
        ST_START,   // next nibble processed is the first of an operation
        ST_RUN      // at least one nibble of the current operation is done
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic        carry;
    logic        eq_acc;
    logic [31:0] result_q;
    logic        carry_out_q;

    logic        is_logic;
    logic        is_sub;
    logic [4:0]  bit_pos;
    logic [3:0]  a_nib;
    logic [3:0]  b_raw;
    logic [3:0]  b_nib;
    logic        c_eff;
    logic [4:0]  sum;
    logic [3:0]  r_nib;
    logic [2:0]  last;
    logic        done;
    logic        eq_next;

    always_comb begin
        is_logic = (bus.ctrl >= 5'd1) && (bus.ctrl <= 5'd4);
`ifdef NIBBLE_ALU_SUB_EN
        is_sub   = (bus.ctrl == 5'd5);
`else
        is_sub   = 1'b0;
`endif
        bit_pos  = {idx, 2'b00};
        a_nib    = bus.word1[bit_pos +: 4];
        // Above the immediate's width the operand is its sign extension.
        b_raw    = (idx > bus.loop_nibbles_number) ? {4{bus.word2_is_signed_and_negative}}
                                                   : bus.word2[bit_pos +: 4];
        b_nib    = is_sub ? ~b_raw : b_raw;
        // SUB is a + ~b + 1: the first nibble always sees carry 1.
        c_eff    = (is_sub && state == ST_START) ? 1'b1 : carry;
        sum      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_eff};

        r_nib = sum[3:0];
        case (bus.ctrl)
            5'd1:    r_nib = a_nib & b_nib;
            5'd2:    r_nib = a_nib | b_nib;
            5'd3:    r_nib = a_nib ^ b_nib;
            5'd4:    r_nib = ~(a_nib ^ b_nib);
            default: r_nib = sum[3:0];
        endcase

        // Negative operands and compares must touch every nibble.
        last = (bus.word2_is_signed_and_negative || bus.check_if_result_0xF) ? LAST_NIB
                                                                            : bus.loop_nibbles_number;
        done = (idx == LAST_NIB) ||
               ((idx >= last) && (is_logic || !sum[4]));

        eq_next  = ((state == ST_START) ? 1'b1 : eq_acc) && (r_nib == 4'hF);

        bus.busy = bus.loop_perm_to_count && !rst && !done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_START;
            idx         <= 3'd0;
            carry       <= 1'b0;
            eq_acc      <= 1'b0;
            result_q    <= 32'd0;
            carry_out_q <= 1'b0;
        end else if (!bus.loop_perm_to_count) begin
            // Idle or aborted: preload result and rearm for a fresh operation.
            state    <= ST_START;
            idx      <= 3'd0;
            carry    <= bus.carry_in;
            result_q <= bus.preinit_result;
        end else begin
            result_q[bit_pos +: 4] <= r_nib;
            eq_acc                 <= eq_next;
            if (done) begin
                // Request still high means back-to-back op without preload.
                state       <= ST_START;
                idx         <= 3'd0;
                carry       <= bus.carry_in;
                carry_out_q <= bus.check_if_result_0xF ? eq_next
                             : (is_logic ? 1'b0 : sum[4]);
            end else begin
                state <= ST_RUN;
                idx   <= idx + 3'd1;
                if (!is_logic) begin
                    carry <= sum[4];
                end
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// tb/tb_loop_over_all_nibbles.sv - self-checking bench for loop_over_all_nibbles
module tb_loop_over_all_nibbles;

    logic clk;
    logic rst;

    loop_over_all_nibbles_if bus ();

    loop_over_all_nibbles dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] pre;
        logic [2:0]  ln;
        logic        neg;
        logic        cmp;
        logic        cin;
        logic [31:0] er;
        logic        ec;
        int          ecyc;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    vec_t sb [$];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(string name, logic [4:0] ctrl, logic [31:0] w1, logic [31:0] w2,
                                logic [31:0] pre, logic [2:0] ln, logic neg, logic cmp, logic cin,
                                logic [31:0] er, logic ec, int ecyc);
        vec_t v;
        v.name = name; v.ctrl = ctrl; v.w1 = w1; v.w2 = w2; v.pre = pre; v.ln = ln;
        v.neg = neg; v.cmp = cmp; v.cin = cin; v.er = er; v.ec = ec; v.ecyc = ecyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic perm);
        bus.ctrl                         = v.ctrl;
        bus.word1                        = v.w1;
        bus.word2                        = v.w2;
        bus.preinit_result               = v.pre;
        bus.loop_nibbles_number          = v.ln;
        bus.word2_is_signed_and_negative = v.neg;
        bus.check_if_result_0xF          = v.cmp;
        bus.carry_in                     = v.cin;
        bus.loop_perm_to_count           = perm;
    endtask

    task automatic run_op(input vec_t v);
        vec_t e;
        int   cyc;
        logic fin;
        logic b;
        @(negedge clk);
        drive(v, 1'b0);
        @(negedge clk);
        sb.push_back(v);
        bus.loop_perm_to_count = 1'b1;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 20) begin
            #1;
            b = bus.busy;
            @(posedge clk);
            cyc++;
            if (!b) fin = 1'b1;
            else @(negedge clk);
        end
        #1;
        e = sb.pop_front();
        chk({e.name, " done"}, {31'd0, fin}, 32'd1);
        chk({e.name, " result"}, bus.result, e.er);
        chk({e.name, " carry_out"}, {31'd0, bus.carry_out}, {31'd0, e.ec});
        chk({e.name, " cycles"}, cyc, e.ecyc);
        @(negedge clk);
        bus.loop_perm_to_count = 1'b0;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = mk("inc_chain",  5'd0, 32'h000000FF, 32'h4,        32'h000000FF, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000103, 1'b0, 3);
        vecs[1]  = mk("signed12",   5'd0, 32'h0000007B, 32'hFFE,      32'h0000007B, 3'd2, 1'b1, 1'b0, 1'b0, 32'h00000079, 1'b1, 8);
        vecs[2]  = mk("cmp_eq",     5'd4, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        3'd7, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 8);
        vecs[3]  = mk("cmp_ne",     5'd4, 32'hDEADBEEF, 32'hDEADBEEE, 32'h0,        3'd7, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 8);
        vecs[4]  = mk("neg_imm",    5'd0, 32'h0,        32'h800,      32'h0,        3'd2, 1'b1, 1'b0, 1'b0, 32'hFFFFF800, 1'b0, 8);
        vecs[5]  = mk("add32_wrap", 5'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        3'd7, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 8);
        vecs[6]  = mk("xor_short",  5'd3, 32'h000000F0, 32'h000000FF, 32'hAAAAAAAA, 3'd1, 1'b0, 1'b0, 1'b0, 32'hAAAAAA0F, 1'b0, 2);
        vecs[7]  = mk("add_cin",    5'd0, 32'h00000010, 32'h0F,       32'h00000010, 3'd1, 1'b0, 1'b0, 1'b1, 32'h00000020, 1'b0, 2);
        vecs[8]  = mk("and32",      5'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        3'd7, 1'b0, 1'b0, 1'b0, 32'hF000F000, 1'b0, 8);
        vecs[9]  = mk("or32",       5'd2, 32'h12345678, 32'h80000001, 32'h0,        3'd7, 1'b0, 1'b0, 1'b0, 32'h92345679, 1'b0, 8);
        vecs[10] = mk("ctrl7_add",  5'd7, 32'h00000001, 32'h2,        32'h00000001, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000003, 1'b0, 1);
`ifdef NIBBLE_ALU_SUB_EN
        vecs[11] = mk("sub",        5'd5, 32'h00000005, 32'h7,        32'h00000005, 3'd7, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 8);
`else
        vecs[11] = mk("ctrl5_add",  5'd5, 32'h00000005, 32'h7,        32'h00000005, 3'd7, 1'b0, 1'b0, 1'b0, 32'h0000000C, 1'b0, 8);
`endif

        rst = 1'b1;
        drive(vecs[0], 1'b0);
        repeat (2) @(negedge clk);
        chk("reset result", bus.result, 32'h0);
        chk("reset carry_out", {31'd0, bus.carry_out}, 32'h0);
        chk("reset busy", {31'd0, bus.busy}, 32'h0);
        rst = 1'b0;

        bus.preinit_result = 32'h00001234;
        @(negedge clk);
        chk("idle preload", bus.result, 32'h00001234);
        chk("idle busy", {31'd0, bus.busy}, 32'h0);

        for (int i = 0; i < NV; i++) run_op(vecs[i]);

        // Abort: drop the request mid-run, result returns to preinit.
        v = mk("abort", 5'd0, 32'hFFFFFFFF, 32'h1, 32'hABCDEF55, 3'd7, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8);
        @(negedge clk);
        drive(v, 1'b0);
        @(negedge clk);
        bus.loop_perm_to_count = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort partial", bus.result, 32'hABCDE000);
        chk("abort busy mid", {31'd0, bus.busy}, 32'h1);
        bus.loop_perm_to_count = 1'b0;
        @(negedge clk);
        chk("abort result", bus.result, 32'hABCDEF55);
        chk("abort busy", {31'd0, bus.busy}, 32'h0);

        // Reset mid-run: immediate return to reset values.
        bus.loop_perm_to_count = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst result", bus.result, 32'h0);
        chk("midrst busy", {31'd0, bus.busy}, 32'h0);
        chk("midrst carry_out", {31'd0, bus.carry_out}, 32'h0);
        bus.loop_perm_to_count = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
